// File: rtl/dbb_pkg.sv
// Shared types and helpers for the density-bound-block scheduler.
package dbb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest mask the popcount helper accepts; narrower masks are zero-extended.
  localparam int MAX_BLOCKS = 64;

  function automatic logic [6:0] popcount(input logic [MAX_BLOCKS-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MAX_BLOCKS; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dbb_lsb_pick.sv
// Combinational lowest-set-bit picker: index, one-hot clear mask and any flag.
module dbb_lsb_pick #(
  parameter  int NUM_BLOCKS = 8,
  localparam int IDX_W      = $clog2(NUM_BLOCKS)
) (
  input  logic [NUM_BLOCKS-1:0] mask,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_BLOCKS-1:0] clear,
  output logic                  any
);

  assign any      = |mask;
  assign clear[0] = mask[0];

  // A bit is the lowest set bit only if every lower bit is clear.
  genvar gi;
  generate
    for (gi = 1; gi < NUM_BLOCKS; gi++) begin : g_clear
      assign clear[gi] = mask[gi] & ~(|mask[gi-1:0]);
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int b = NUM_BLOCKS - 1; b >= 0; b--) begin
      if (mask[b]) begin
        idx = IDX_W'(b);
      end
    end
  end

endmodule

// File: rtl/dbb_block_scheduler.sv
// Walks a per-job block mask lowest index first, enabling the SA for
// RUN_CYCLES cycles per non-zero block and skipping zero blocks.
module dbb_block_scheduler
  import dbb_pkg::*;
#(
  parameter  int NUM_BLOCKS = 8,
  parameter  int RUN_CYCLES = 4,
  localparam int IDX_W      = $clog2(NUM_BLOCKS),
  localparam int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [NUM_BLOCKS-1:0] i_mask,
  input  logic                  i_hold,
  input  logic                  i_abort,
  output logic                  o_enable,
  output logic [IDX_W-1:0]      o_blk_idx,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_nnz
);

  localparam int            RUN_W    = $clog2(RUN_CYCLES + 1);
  localparam logic [RUN_W-1:0] CNT_LAST = RUN_W'(RUN_CYCLES - 1);

  generate
    if (NUM_BLOCKS < 2) begin : g_bad_blocks
      $error("dbb_block_scheduler: NUM_BLOCKS must be >= 2");
    end
    if (NUM_BLOCKS > MAX_BLOCKS) begin : g_too_many_blocks
      $error("dbb_block_scheduler: NUM_BLOCKS exceeds popcount width");
    end
    if (RUN_CYCLES < 1) begin : g_bad_run
      $error("dbb_block_scheduler: RUN_CYCLES must be >= 1");
    end
  endgenerate

  state_t                state_reg;
  logic [NUM_BLOCKS-1:0] mask_q;
  logic [IDX_W-1:0]      idx_reg;
  logic [RUN_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      nnz_reg;

  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_BLOCKS-1:0] pick_clear;
  logic                  pick_any;

  dbb_lsb_pick #(.NUM_BLOCKS(NUM_BLOCKS)) u_pick (
    .mask  (mask_q),
    .idx   (pick_idx),
    .clear (pick_clear),
    .any   (pick_any)
  );

  assign o_enable  = (state_reg == RUN) && !i_hold;
  assign o_last    = o_enable && (cnt_reg == CNT_LAST) && (mask_q == '0);
  assign o_busy    = (state_reg != IDLE);
  assign o_done    = (state_reg == DONE);
  assign o_blk_idx = idx_reg;
  assign o_nnz     = nnz_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      mask_q    <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      nnz_reg   <= '0;
    end else if (i_abort) begin
      // Cancel keeps the last index and count visible for debug.
      state_reg <= IDLE;
      mask_q    <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            mask_q    <= i_mask;
            nnz_reg   <= CNT_W'(popcount(MAX_BLOCKS'(i_mask)));
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (!pick_any) begin
            state_reg <= DONE;
          end else begin
            idx_reg   <= pick_idx;
            mask_q    <= mask_q & ~pick_clear;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!i_hold) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
              state_reg <= (mask_q == '0) ? DONE : SCAN;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbb_block_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed enable/done events, a
// monitor pops and compares whenever the scheduler presents one.
module tb_dbb_block_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_mask = 8'h00;
  logic       i_hold = 1'b0;
  logic       i_abort = 1'b0;
  logic       o_enable, o_last, o_busy, o_done;
  logic [2:0] o_blk_idx;
  logic [3:0] o_nnz;

  logic       start1 = 1'b0;
  logic       en1, last1, busy1, done1;
  logic [2:0] idx1;
  logic [3:0] nnz1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  typedef struct {
    bit       is_done;
    int       rel;
    int       idx;
    bit       last;
    int       nnz;
  } exp_t;

  exp_t sb[$];

  dbb_block_scheduler #(.NUM_BLOCKS(8), .RUN_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mask(i_mask),
    .i_hold(i_hold), .i_abort(i_abort), .o_enable(o_enable),
    .o_blk_idx(o_blk_idx), .o_last(o_last), .o_busy(o_busy),
    .o_done(o_done), .o_nnz(o_nnz)
  );

  dbb_block_scheduler #(.NUM_BLOCKS(8), .RUN_CYCLES(1)) u_dut_r1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_mask(i_mask),
    .i_hold(1'b0), .i_abort(1'b0), .o_enable(en1),
    .o_blk_idx(idx1), .o_last(last1), .o_busy(busy1),
    .o_done(done1), .o_nnz(nnz1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic expect_run(input int idx, input int first, input bit last_job, input int nnz);
    for (int r = 0; r < 4; r++) begin
      sb.push_back('{is_done: 1'b0, rel: first + r, idx: idx,
                     last: (last_job && r == 3), nnz: nnz});
    end
  endtask

  task automatic expect_one(input int idx, input int rel, input bit last, input int nnz);
    sb.push_back('{is_done: 1'b0, rel: rel, idx: idx, last: last, nnz: nnz});
  endtask

  task automatic expect_done(input int rel, input int nnz);
    sb.push_back('{is_done: 1'b1, rel: rel, idx: 0, last: 1'b0, nnz: nnz});
  endtask

  // Cycle 0 is the cycle in which i_start is sampled.
  task automatic start_job(input logic [7:0] m);
    @(negedge clk);
    i_start = 1'b1;
    i_mask  = m;
    t0      = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < t0 + n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk({name, "_pending_events"}, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: sample just before the next rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst && (o_enable || o_done)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event rel=%0d actual enable=%0d done=%0d idx=%0d required none",
                 cyc - t0, o_enable, o_done, o_blk_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn rel=%0d enable=%0d done=%0d idx=%0d last=%0d nnz=%0d",
                 cyc - t0, o_enable, o_done, o_blk_idx, o_last, o_nnz);
        chk("ev_done", int'(o_done), int'(e.is_done));
        chk("ev_cycle", cyc - t0, e.rel);
        chk("ev_busy", int'(o_busy), 1);
        chk("ev_nnz", int'(o_nnz), e.nnz);
        if (!e.is_done) begin
          chk("ev_idx", int'(o_blk_idx), e.idx);
          chk("ev_last", int'(o_last), int'(e.last));
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #3;
    chk("rst_enable", int'(o_enable), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_nnz", int'(o_nnz), 0);
    chk("rst_idx", int'(o_blk_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero mask: done in cycle 2, no enables.
    expect_done(2, 0);
    start_job(8'h00);
    drain("zero_mask");

    // Three blocks 0, 2, 7 with single SCAN gaps.
    expect_run(0, 2, 1'b0, 3);
    expect_run(2, 7, 1'b0, 3);
    expect_run(7, 12, 1'b1, 3);
    expect_done(16, 3);
    start_job(8'b1000_0101);
    drain("three_blocks");

    // Hold for cycles 3..5 stretches the single block.
    expect_one(0, 2, 1'b0, 1);
    expect_one(0, 6, 1'b0, 1);
    expect_one(0, 7, 1'b0, 1);
    expect_one(0, 8, 1'b1, 1);
    expect_done(9, 1);
    start_job(8'h01);
    goto_cycle(3);
    i_hold = 1'b1;
    goto_cycle(6);
    i_hold = 1'b0;
    drain("hold");

    // Abort in cycle 8, the second RUN cycle of block 1.
    expect_run(0, 2, 1'b0, 2);
    expect_one(1, 7, 1'b0, 2);
    expect_one(1, 8, 1'b0, 2);
    start_job(8'h03);
    goto_cycle(8);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    #3;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_enable", int'(o_enable), 0);
    chk("abort_nnz_hold", int'(o_nnz), 2);
    chk("abort_idx_hold", int'(o_blk_idx), 1);
    drain("abort");

    expect_run(7, 2, 1'b1, 1);
    expect_done(6, 1);
    start_job(8'h80);
    drain("after_abort");

    // Start pulse while busy must not disturb the job.
    expect_run(0, 2, 1'b0, 2);
    expect_run(2, 7, 1'b1, 2);
    expect_done(11, 2);
    start_job(8'h05);
    goto_cycle(4);
    i_start = 1'b1;
    i_mask  = 8'hFF;
    @(negedge clk);
    i_start = 1'b0;
    drain("busy_start");

    // Asynchronous reset mid-RUN.
    expect_one(0, 2, 1'b0, 1);
    expect_one(0, 3, 1'b0, 1);
    start_job(8'h01);
    goto_cycle(3);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_enable", int'(o_enable), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_done", int'(o_done), 0);
    chk("arst_last", int'(o_last), 0);
    chk("arst_nnz", int'(o_nnz), 0);
    chk("arst_idx", int'(o_blk_idx), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain("async_reset");

    // RUN_CYCLES=1 legacy timing on the second instance.
    @(negedge clk);
    start1 = 1'b1;
    i_mask = 8'h01;
    t0     = cyc;
    @(negedge clk);
    start1 = 1'b0;
    #3;
    chk("r1_c1_busy", int'(busy1), 1);
    chk("r1_c1_enable", int'(en1), 0);
    @(negedge clk);
    #3;
    chk("r1_c2_enable", int'(en1), 1);
    chk("r1_c2_idx", int'(idx1), 0);
    chk("r1_c2_last", int'(last1), 1);
    @(negedge clk);
    #3;
    chk("r1_c3_done", int'(done1), 1);
    chk("r1_c3_enable", int'(en1), 0);
    chk("r1_c3_nnz", int'(nnz1), 1);
    @(negedge clk);
    #3;
    chk("r1_c4_busy", int'(busy1), 0);
    chk("r1_c4_done", int'(done1), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
